m_uart_rx: RTL
==============

# m_uart_rx

Byte-oriented 8N1 UART receiver, the receive-side counterpart of the SoC's UART transmitter. It replaces the constant-high tie-off on the SoC `uart_rx` input, and the sim top uses it to decode `o_tx` back into bytes. It oversamples the line 16x, validates start and stop bits, and buffers received bytes behind a valid/ready output.

## Interface
- `CLK_HZ`, default 27000000: input clock frequency.
- `BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 8: buffer depth, a power of 2. Used only with `UART_RX_FIFO_EN`.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `i_rx`, in, 1: serial line, asynchronous to `clk`, idles high.
- `o_data`, out, 8: received byte at the buffer head.
- `o_valid`, out, 1: `o_data` holds an unread byte.
- `i_ready`, in, 1: consumer accepts the byte when `o_valid & i_ready`.
- `o_frame_err`, out, 1: one-cycle pulse when the stop bit samples low.
- `o_overrun`, out, 1: one-cycle pulse when a good byte is dropped because the buffer is full.

## Operation
- `i_rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- Tick generator:
  - `DIV = (CLK_HZ + 8*BAUD) / (16*BAUD)`, an integer constant of at least 1.
  - Counter counts `0..DIV-1` and emits a one-cycle `tick` at `DIV-1`.
  - Counter free-runs but is cleared on the start edge so that phase aligns to the edge.
- FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
  - IDLE: on synced line high→low, clear the tick counter and sample counter, then go to START.
  - START: after 8 ticks (mid-bit), sample the line.
    - Low: go to DATA with bit index 0.
    - High: treat as a glitch and return to IDLE with no output.
  - DATA: every 16 ticks, sample into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: 16 ticks later, sample the line.
    - High: push the byte and go to IDLE.
    - Low: pulse `o_frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for the synced line to be high, then go to IDLE. This covers a break or a held-low line.
- Push:
  - If the buffer is not full, or a pop happens in the same cycle, the byte is stored.
  - Otherwise the byte is dropped, `o_overrun` pulses, and stored contents are unchanged.
- Pop: `o_valid & i_ready` removes the head. `i_ready` while empty has no effect.
- Push and pop in the same cycle:
  - Both succeed.
  - Occupancy is unchanged.
  - No overrun is flagged, even when the buffer is full.
- Back-to-back frames: a new start edge is accepted from the IDLE cycle directly after the STOP sample, with no extra idle time required.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_overrun`=0. Buffer is empty and FSM is in IDLE.
- Asserting `rst` mid-frame discards the partial byte and all buffered bytes.
- Input latency: 2 clocks through the synchronizer.
- Output latency:
  - `o_valid` rises in the clock after the STOP-sample tick.
  - That is 2 + 16·DIV·9 + 8·DIV + 1 clocks after the `i_rx` falling edge (±1 for tick phase).
  - `o_frame_err` and `o_overrun` pulse in the same relative cycle.
- `o_data` is registered and stable while `o_valid` is high and `i_ready` is low.
- Tolerance: correct reception for a baud mismatch of up to ±3%.

## Configuration
- `UART_RX_FIFO_EN` defined: `FIFO_DEPTH`-entry circular FIFO.
  - Read and write pointers are `$clog2(FIFO_DEPTH)+1` bits wide, with wrap detected by the MSB.
  - Output is first-word-fall-through.
- `UART_RX_FIFO_EN` undefined: single holding register.
  - Effective depth is 1.
  - Same push, pop and overrun rules.
  - `FIFO_DEPTH` is ignored.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding.
  - `UART_OVERSAMPLE = 16`.
  - Divisor function.
  - The same divisor is reused by the transmitter.
- Sub-module `m_uart_rx_fifo`: the valid/ready buffer.
  - Push and pop ports.
  - Full and empty flags.
  - Both the FIFO and the single-register variant are selected inside it by `UART_RX_FIFO_EN`.
- Top module: synchronizer, tick generator, FSM, shift register.

## Test plan
All scenarios use `CLK_HZ=1600000`, `BAUD=10000` (`DIV=10`, 160 clocks per bit), with `UART_RX_FIFO_EN` defined and `FIFO_DEPTH=8` unless noted.
- Single frame: send 0x55 with `i_ready=1`. Require `o_valid` for exactly 1 cycle with `o_data=0x55`, about 1523 clocks after the start edge, and no error pulses.
- Glitch: drive `i_rx` low for 3 clocks, then high for 2000 clocks. Require no `o_valid` and no `o_frame_err`. A following 0xA3 frame must then be received correctly.
- Framing error: send 0xA5 with the stop bit low and the line held low for 3 bit times. Require one `o_frame_err` pulse and no `o_valid`. After the line returns high, 0x3C must be received.
- Overrun: with `i_ready=0`, send 0x00..0x08 back-to-back. Require one `o_overrun` pulse on the 9th byte. Then raise `i_ready` and require 0x00..0x07 in order, after which `o_valid` is low.
- Full plus simultaneous pop: fill the buffer with 8 bytes, then pulse `i_ready` in the exact push cycle of byte 9. Require no overrun and 8 bytes remaining.
- Reset mid-frame: assert `rst` during DATA bit 4 with 2 bytes buffered. Require all outputs 0 and the buffer empty, and the next full frame 0x7E to be received correctly.
- Without `UART_RX_FIFO_EN`: rerun the overrun scenario. Require the overrun pulse on byte 2 and only 0x00 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver FSM encoding and baud divisor (also used by the transmitter).
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_e;
  // Rounded clocks per oversample tick, never below 1.
  function automatic int uart_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (UART_OVERSAMPLE / 2) * baud) / (UART_OVERSAMPLE * baud);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/m_uart_rx_fifo.sv
// m_uart_rx_fifo: valid/ready receive buffer; UART_RX_FIFO_EN selects a DEPTH-entry FWFT FIFO, else a single holding register.
module m_uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_overrun
);
  logic w_rd, w_wr;
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);
  always_ff @(posedge clk or posedge rst)
    if (rst) o_overrun <= 1'b0;
    else o_overrun <= i_push & ~w_wr;
`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_mem  <= '{default: '0};
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
`else
  logic [7:0] r_data;
  logic r_valid;
  logic w_unused_depth;
  assign w_unused_depth = ^DEPTH;
  assign o_data  = r_data;
  assign o_full  = r_valid;
  assign o_empty = ~r_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_wr | (r_valid & ~w_rd);
      if (w_wr) r_data <= i_data;
    end
`endif
endmodule

// File: rtl/m_uart_rx.sv
// m_uart_rx: 8N1 UART receiver with 16x oversampling and a valid/ready output buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register is used.
module m_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);
  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  // [1:0] synchronizer, [2] previous synced level for falling-edge detect.
  logic [2:0] r_sync;
  rx_state_e r_state;
  logic [DW-1:0] r_div;
  logic [3:0] r_tcnt;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic w_rx, w_start, w_tick, w_stop_smp, w_push, w_empty, w_unused_full;
  assign w_rx       = r_sync[1];
  assign w_start    = (r_state == S_IDLE) & r_sync[2] & ~w_rx;
  assign w_tick     = r_div == DW'(DIV - 1);
  assign w_stop_smp = (r_state == S_STOP) & w_tick & (r_tcnt == 4'd15);
  assign w_push     = w_stop_smp & w_rx;
  assign o_valid    = ~w_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= 3'b111;
    else r_sync <= {r_sync[1:0], i_rx};
  // Free-running tick counter, re-phased to the start edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_div <= '0;
    else r_div <= (w_start | w_tick) ? '0 : r_div + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= w_stop_smp & ~w_rx;
      case (r_state)
        S_IDLE:
          if (w_start) begin
            r_tcnt  <= '0;
            r_state <= S_START;
          end
        S_START:
          if (w_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == 4'd7) begin
              r_tcnt  <= '0;
              r_bit   <= '0;
              r_state <= w_rx ? S_IDLE : S_DATA;
            end
          end
        S_DATA:
          if (w_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == 4'd15) begin
              r_shift <= {w_rx, r_shift[7:1]};
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) r_state <= S_STOP;
            end
          end
        S_STOP:
          if (w_tick) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == 4'd15) r_state <= w_rx ? S_IDLE : S_BREAK;
          end
        S_BREAK: if (w_rx) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  m_uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_data    (r_shift),
    .i_pop     (i_ready),
    .o_data    (o_data),
    .o_full    (w_unused_full),
    .o_empty   (w_empty),
    .o_overrun (o_overrun)
  );
endmodule
